intr_seq: RTL and testbench

Interrupt and return-from-interrupt sequencer for the 8-bit RISC pipeline. It latches the external interrupt request and drains the pipeline. It then pushes the return PC to the stack, pulses the execute stage's flag-save strobe, fetches the ISR vector and redirects the PC. For RTI it generates the execute stage's flag-restore strobe, aligned with the cycle in which the return branch is taken.

---
 rtl/isa_pkg.sv | 22 ++
 rtl/intr_latch.sv | 31 +++
 rtl/intr_seq.sv | 130 +++++++++++++
 tb/tb_intr_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA constants for the 8-bit RISC pipeline: sequencer state encoding,
// jump-type codes and the default interrupt vector location.
package isa_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DRAIN = 3'd1;
    localparam logic [2:0] ST_PUSH  = 3'd2;
    localparam logic [2:0] ST_VEC   = 3'd3;
    localparam logic [2:0] ST_LOAD  = 3'd4;

    typedef enum logic [2:0] {
        StIdle  = ST_IDLE,
        StDrain = ST_DRAIN,
        StPush  = ST_PUSH,
        StVec   = ST_VEC,
        StLoad  = ST_LOAD
    } seq_state_e;

    localparam logic [2:0] JT_RET              = 3'd6;
    localparam logic [7:0] DEFAULT_VECTOR_ADDR = 8'd1;

endpackage

// File: rtl/intr_latch.sv
// Rising-edge detector for the external interrupt line plus the pending latch
// that holds one request until the sequencer reaches its stack push.
module intr_latch (
    input  logic clk,
    input  logic reset,
    input  logic intr_in,
    input  logic clr,
    output logic pending
);

    logic intr_q;
    logic pending_q;
    logic rise;

    assign rise = intr_in & ~intr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            intr_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            intr_q    <= intr_in;
            // A fresh edge in the clearing cycle is a new request and survives.
            pending_q <= rise | (pending_q & ~clr);
        end
    end

    // The edge is forwarded in its own cycle so the drain can start one cycle later.
    assign pending = pending_q | rise;

endmodule

// File: rtl/intr_seq.sv
// Interrupt entry / RTI sequencer: drains the pipeline, pushes the return PC,
// fetches the ISR vector and redirects fetch; strobes flag save/restore.
module intr_seq
    import isa_pkg::*;
#(
    parameter logic [7:0]  VECTOR_ADDR  = DEFAULT_VECTOR_ADDR,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       intr_in,
    input  logic       rti_ex,
    input  logic [7:0] ret_pc,
    input  logic [7:0] sp,
    input  logic [7:0] mem_rdata,
    output logic       stall_fetch,
    output logic       mem_we,
    output logic       mem_re,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       sp_dec,
    output logic       intr_ack,
    output logic       restore_flags,
    output logic       pc_load,
    output logic [7:0] pc_load_val,
    output logic       in_isr
);

    localparam logic [7:0] DrainLoad = 8'(DRAIN_CYCLES - 1);

    seq_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] ret_q, ret_d;
    logic       in_isr_q, in_isr_d;
    logic       rti_wait_q, rti_wait_d;
    logic       pending;
    logic       clr;
    logic       start_blocked;

    intr_latch u_intr_latch (
        .clk     (clk),
        .reset   (reset),
        .intr_in (intr_in),
        .clr     (clr),
        .pending (pending)
    );

    // Uses the post-restore view so a held request starts right after the restore cycle.
    assign start_blocked = (in_isr_q & ~rti_wait_q) | rti_ex;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= 8'h00;
            ret_q      <= 8'h00;
            in_isr_q   <= 1'b0;
            rti_wait_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ret_q      <= ret_d;
            in_isr_q   <= in_isr_d;
            rti_wait_q <= rti_wait_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ret_d         = ret_q;
        in_isr_d      = in_isr_q & ~rti_wait_q;
        rti_wait_d    = rti_ex;
        clr           = 1'b0;
        stall_fetch   = 1'b0;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        mem_addr      = 8'h00;
        mem_wdata     = 8'h00;
        sp_dec        = 1'b0;
        intr_ack      = 1'b0;
        restore_flags = rti_wait_q;
        pc_load       = 1'b0;
        pc_load_val   = 8'h00;

        unique case (state_q)
            StIdle: begin
                if (pending && !start_blocked) begin
                    state_d = StDrain;
                    cnt_d   = DrainLoad;
                end
            end
            StDrain: begin
                stall_fetch = 1'b1;
                if (cnt_q == 8'h00) begin
                    ret_d   = ret_pc;
                    state_d = StPush;
                end else begin
                    cnt_d = cnt_q - 8'h01;
                end
            end
            StPush: begin
                stall_fetch = 1'b1;
                mem_we      = 1'b1;
                mem_addr    = sp;
                mem_wdata   = ret_q;
                sp_dec      = 1'b1;
                intr_ack    = 1'b1;
                clr         = 1'b1;
                in_isr_d    = 1'b1;
                state_d     = StVec;
            end
            StVec: begin
                stall_fetch = 1'b1;
                mem_re      = 1'b1;
                mem_addr    = VECTOR_ADDR;
                state_d     = StLoad;
            end
            StLoad: begin
                stall_fetch = 1'b1;
                pc_load     = 1'b1;
                pc_load_val = mem_rdata;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_isr = in_isr_q;

endmodule

// File: tb/tb_intr_seq.sv
// Directed self-checking bench for intr_seq: default build plus a
// DRAIN_CYCLES=1 build sharing the same stimulus.
module tb_intr_seq;

    logic       clk;
    logic       reset;
    logic       intr_in;
    logic       rti_ex;
    logic [7:0] ret_pc;
    logic [7:0] sp;

    logic [7:0] rdata0, rdata1;
    logic       stall0, we0, re0, spdec0, ack0, rest0, pcl0, isr0;
    logic [7:0] addr0, wdata0, pcv0;
    logic       stall1, we1, re1, spdec1, ack1, rest1, pcl1, isr1;
    logic [7:0] addr1, wdata1, pcv1;

    int checks;
    int failures;
    int ack_cnt;

    intr_seq u_dut (
        .clk           (clk),
        .reset         (reset),
        .intr_in       (intr_in),
        .rti_ex        (rti_ex),
        .ret_pc        (ret_pc),
        .sp            (sp),
        .mem_rdata     (rdata0),
        .stall_fetch   (stall0),
        .mem_we        (we0),
        .mem_re        (re0),
        .mem_addr      (addr0),
        .mem_wdata     (wdata0),
        .sp_dec        (spdec0),
        .intr_ack      (ack0),
        .restore_flags (rest0),
        .pc_load       (pcl0),
        .pc_load_val   (pcv0),
        .in_isr        (isr0)
    );

    intr_seq #(
        .DRAIN_CYCLES (1)
    ) u_dut1 (
        .clk           (clk),
        .reset         (reset),
        .intr_in       (intr_in),
        .rti_ex        (rti_ex),
        .ret_pc        (ret_pc),
        .sp            (sp),
        .mem_rdata     (rdata1),
        .stall_fetch   (stall1),
        .mem_we        (we1),
        .mem_re        (re1),
        .mem_addr      (addr1),
        .mem_wdata     (wdata1),
        .sp_dec        (spdec1),
        .intr_ack      (ack1),
        .restore_flags (rest1),
        .pc_load       (pcl1),
        .pc_load_val   (pcv1),
        .in_isr        (isr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous data memory: vector slot holds 8'h40, everything else 8'hEE.
    always @(posedge clk) begin
        if (re0) rdata0 <= (addr0 == 8'd1) ? 8'h40 : 8'hEE;
        if (re1) rdata1 <= (addr1 == 8'd1) ? 8'h40 : 8'hEE;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; callers then drive and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        intr_in  = 1'b0;
        rti_ex   = 1'b0;
        ret_pc   = 8'h00;
        sp       = 8'h00;
        rdata0   = 8'h00;
        rdata1   = 8'h00;

        // Reset state.
        step();
        #1;
        check("reset_ctl", {8'h00, stall0, we0, re0, spdec0, ack0, rest0, pcl0, isr0}, 16'h0000);
        check("reset_bus", {addr0, wdata0}, 16'h0000);
        reset = 1'b0;

        // Basic entry: edge in cycle T.
        sp     = 8'hFF;
        ret_pc = 8'h23;
        step(); intr_in = 1'b1; #1;                 // T
        check("entry_T_nostall", {15'd0, stall0}, 16'd0);
        step(); intr_in = 1'b0; #1;                 // T+1
        check("entry_T1_stall", {15'd0, stall0}, 16'd1);
        check("entry_T1_nowe", {15'd0, we0}, 16'd0);
        step(); #1;                                 // T+2
        step(); #1;                                 // T+3
        check("entry_T3_nowe", {15'd0, we0}, 16'd0);
        step(); #1;                                 // T+4 push
        check("push_strobes", {13'd0, we0, ack0, spdec0}, 16'h0007);
        check("push_bus", {addr0, wdata0}, 16'hFF23);
        step(); #1;                                 // T+5 vector fetch
        check("vec_read", {7'd0, re0, addr0}, 16'h0101);
        check("vec_isr", {15'd0, isr0}, 16'd1);
        step(); #1;                                 // T+6 load
        check("load_pc", {7'd0, pcl0, pcv0}, 16'h0140);
        step(); #1;                                 // T+7
        check("post_load", {14'd0, stall0, isr0}, 16'h0001);

        // Nested hold: an edge during the ISR must not stall fetch.
        intr_in = 1'b1; #1;
        step(); intr_in = 1'b0; #1;
        step(); #1;
        check("nested_nostall", {15'd0, stall0}, 16'd0);

        // RTI at T releases the held request.
        step(); rti_ex = 1'b1; #1;                  // T
        check("rti_T_norestore", {15'd0, rest0}, 16'd0);
        step(); rti_ex = 1'b0; #1;                  // T+1
        check("rti_T1_restore", {13'd0, rest0, stall0, isr0}, 16'h0005);
        step(); #1;                                 // T+2
        check("rti_T2_drain", {13'd0, rest0, stall0, isr0}, 16'h0002);
        step(); #1;
        step(); #1;
        step(); #1;                                 // T+5 push
        check("nested_push", {15'd0, ack0}, 16'd1);
        step(); #1;
        step(); #1;                                 // T+7 load
        check("nested_load", {7'd0, pcl0, pcv0}, 16'h0140);

        // Edge absorption: three edges, one acknowledge.
        do_reset();
        ack_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            intr_in = (i == 0 || i == 2 || i == 4);
            #1;
            ack_cnt += int'(ack0);
        end
        intr_in = 1'b0;
        check("absorb_one_ack", 16'(ack_cnt), 16'd1);

        // Reset mid-drain aborts everything.
        do_reset();
        step(); intr_in = 1'b1; #1;                 // T
        step(); intr_in = 1'b0; #1;                 // T+1
        check("middrain_stall", {15'd0, stall0}, 16'd1);
        step(); reset = 1'b1; #1;
        check("middrain_reset", {8'h00, stall0, we0, re0, spdec0, ack0, rest0, pcl0, isr0}, 16'h0000);
        step(); reset = 1'b0; #1;
        ack_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(); #1;
            ack_cnt += int'(stall0) + int'(we0);
        end
        check("postreset_idle", 16'(ack_cnt), 16'd0);

        // DRAIN_CYCLES=1 build.
        sp     = 8'h80;
        ret_pc = 8'h5A;
        step(); intr_in = 1'b1; #1;                 // T
        check("d1_T_nostall", {15'd0, stall1}, 16'd0);
        step(); intr_in = 1'b0; #1;                 // T+1
        check("d1_T1_drain", {14'd0, stall1, we1}, 16'h0002);
        step(); #1;                                 // T+2
        check("d1_push", {13'd0, we1, ack1, spdec1}, 16'h0007);
        check("d1_push_bus", {addr1, wdata1}, 16'h805A);
        step(); #1;                                 // T+3
        check("d1_noload_early", {15'd0, pcl1}, 16'd0);
        step(); #1;                                 // T+4
        check("d1_load", {7'd0, pcl1, pcv1}, 16'h0140);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
